// File: rtl/pulse_tx_queue_pkg.sv
// rtl/pulse_tx_queue_pkg.sv - shared types and defaults for the pulse transmit queue
// Purpose: FSM state encoding and default parameter values used by pulse_tx_queue.
package pulse_tx_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } ptq_state_t;

  localparam int PTQ_CNT_W_DEF  = 4;
  localparam int PTQ_TO_CYC_DEF = 255;

endpackage

// File: rtl/pulse_tx_queue_sync_2ff.sv
// rtl/pulse_tx_queue_sync_2ff.sv - two-flop level synchronizer
// Purpose: brings an asynchronous level into the i_clk domain; reusable on either side.
// Ports:
//   i_clk   - destination clock
//   i_rst_n - synchronous active-low reset, output resets to 0
//   i_d     - asynchronous level input
//   o_q     - synchronized level, two i_clk edges behind i_d
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pulse_tx_queue.sv
// rtl/pulse_tx_queue.sv - source-side four-phase pulse transmitter with pending queue
// Purpose: counts incoming pulses and launches them one at a time as a request level,
//          waiting for the returned acknowledge level before the next launch.
// Optional feature: PULSE_TX_TIMEOUT_EN adds an acknowledge timeout and to_err_a.
// Ports:
//   clka      - sending-domain clock
//   rst_n     - synchronous active-low reset
//   pulse_ina - single-cycle event to transfer
//   ack_async - acknowledge level from the destination domain (unsynchronized)
//   clr_ina   - clears the sticky flags ovf_a and to_err_a
//   req_a     - registered request level
//   busy_a    - FSM not idle
//   pend_a    - queued pulses not yet launched
//   done_a    - one-cycle strobe when a transfer completes
//   ovf_a     - sticky, a pulse was dropped on a full queue
//   to_err_a  - sticky acknowledge timeout (0 without the timeout feature)
module pulse_tx_queue
  import pulse_tx_queue_pkg::*;
#(
  parameter int CNT_W  = PTQ_CNT_W_DEF,
  parameter int TO_CYC = PTQ_TO_CYC_DEF
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic             pulse_ina,
  input  logic             ack_async,
  input  logic             clr_ina,
  output logic             req_a,
  output logic             busy_a,
  output logic [CNT_W-1:0] pend_a,
  output logic             done_a,
  output logic             ovf_a,
  output logic             to_err_a
);

  if (CNT_W < 1 || TO_CYC < 2) begin : g_bad_param
    $error("pulse_tx_queue: CNT_W must be >= 1 and TO_CYC >= 2");
  end

  ptq_state_t       r_state;
  logic             r_req;
  logic             r_done;
  logic             r_ovf;
  logic [CNT_W-1:0] r_pend;
  logic             w_ack_s;
  logic             w_launch;
  logic             w_full;
  logic             w_to_hit;

  sync_2ff u_ack_sync (
    .i_clk   (clka),
    .i_rst_n (rst_n),
    .i_d     (ack_async),
    .o_q     (w_ack_s)
  );

  assign w_launch = (r_state == ST_IDLE) && (r_pend != '0);
  assign w_full   = &r_pend;

`ifdef PULSE_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_to_err;
  logic            w_step;

  // Fires on the edge that would bring the count to TO_CYC, so req_a drops
  // exactly TO_CYC cycles after the launch edge.
  assign w_to_hit = (r_state != ST_IDLE) && (r_to_cnt == TO_W'(TO_CYC - 1));
  assign w_step   = w_launch || w_to_hit ||
                    ((r_state == ST_REQ) && w_ack_s) ||
                    ((r_state == ST_REL) && !w_ack_s);

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      if (w_step || (r_state == ST_IDLE)) r_to_cnt <= '0;
      else                                r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_to_hit)     r_to_err <= 1'b1;
      else if (clr_ina) r_to_err <= 1'b0;
    end
  end

  assign to_err_a = r_to_err;
`else
  assign w_to_hit = 1'b0;
  assign to_err_a = 1'b0;
`endif

  // Handshake FSM; the timeout abandons the in-flight pulse without done_a.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (w_to_hit || w_ack_s) begin
            r_state <= w_to_hit ? ST_IDLE : ST_REL;
            r_req   <= 1'b0;
          end
        end
        ST_REL: begin
          if (w_to_hit) begin
            r_state <= ST_IDLE;
          end else if (!w_ack_s) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // Saturating pending counter; a pulse coinciding with a launch nets to zero.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      case ({pulse_ina, w_launch})
        2'b10:   if (!w_full) r_pend <= r_pend + CNT_W'(1);
        2'b01:   r_pend <= r_pend - CNT_W'(1);
        default: r_pend <= r_pend;
      endcase
      if (pulse_ina && !w_launch && w_full) r_ovf <= 1'b1;
      else if (clr_ina)                     r_ovf <= 1'b0;
    end
  end

  assign req_a  = r_req;
  assign busy_a = (r_state != ST_IDLE);
  assign pend_a = r_pend;
  assign done_a = r_done;
  assign ovf_a  = r_ovf;

endmodule

// File: tb/tb_pulse_tx_queue.sv
// tb/tb_pulse_tx_queue.sv - directed self-checking bench for pulse_tx_queue
module tb_pulse_tx_queue;

  localparam int CNT_W  = 4;
  localparam int TO_CYC = 16;

  logic             clka = 1'b0;
  logic             rst_n;
  logic             pulse_ina;
  logic             clr_ina;
  logic             ack_async;
  logic             req_a;
  logic             busy_a;
  logic [CNT_W-1:0] pend_a;
  logic             done_a;
  logic             ovf_a;
  logic             to_err_a;

  logic       ack_en;
  logic [2:0] dly = 3'b000;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clka = ~clka;

  // Destination stand-in: acknowledge echoes req_a three cycles later when enabled.
  always @(posedge clka) dly <= {dly[1:0], req_a};
  assign ack_async = ack_en & dly[2];

  pulse_tx_queue #(
    .CNT_W  (CNT_W),
    .TO_CYC (TO_CYC)
  ) dut (
    .clka      (clka),
    .rst_n     (rst_n),
    .pulse_ina (pulse_ina),
    .ack_async (ack_async),
    .clr_ina   (clr_ina),
    .req_a     (req_a),
    .busy_a    (busy_a),
    .pend_a    (pend_a),
    .done_a    (done_a),
    .ovf_a     (ovf_a),
    .to_err_a  (to_err_a)
  );

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    pulse_ina = 1'b0;
    clr_ina   = 1'b0;
    repeat (4) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int dones;
    int rises;
    int peak;
    logic prev_req;

    ack_en = 1'b1;
    do_reset();

    // Reset state
    chk("rst_req",    32'(req_a),    0);
    chk("rst_busy",   32'(busy_a),   0);
    chk("rst_pend",   32'(pend_a),   0);
    chk("rst_done",   32'(done_a),   0);
    chk("rst_ovf",    32'(ovf_a),    0);
    chk("rst_to_err", 32'(to_err_a), 0);

    // Single pulse with echoed acknowledge
    pulse_ina = 1'b1;
    tick();
    pulse_ina = 1'b0;
    chk("single_pend1", 32'(pend_a), 1);
    chk("single_req0",  32'(req_a),  0);
    tick();
    chk("single_req1",  32'(req_a),  1);
    chk("single_busy",  32'(busy_a), 1);
    chk("single_pend0", 32'(pend_a), 0);
    cyc = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (done_a) begin
        cyc = i;
        break;
      end
    end
    chk("single_done_lat", 32'(cyc), 12);
    tick();
    chk("single_done_once", 32'(done_a), 0);
    chk("single_idle",      32'(busy_a), 0);
    chk("single_pend_end",  32'(pend_a), 0);

    // Burst of 5 while a primer transfer is in flight
    dones = 0;
    rises = 0;
    peak  = 0;
    prev_req = req_a;
    pulse_ina = 1'b1;
    tick();
    pulse_ina = 1'b0;
    tick();
    if (req_a && !prev_req) rises++;
    prev_req = req_a;
    pulse_ina = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i == 5) pulse_ina = 1'b0;
      tick();
      if (32'(pend_a) > peak) peak = 32'(pend_a);
      if (done_a) dones++;
      if (req_a && !prev_req) rises++;
      prev_req = req_a;
      if (i > 5 && !busy_a && pend_a == '0) break;
    end
    chk("burst_peak",  32'(peak),  5);
    chk("burst_dones", 32'(dones), 6);
    chk("burst_reqs",  32'(rises), 6);
    chk("burst_ovf",   32'(ovf_a), 0);

    // Overflow with acknowledge held low
    ack_en = 1'b0;
    do_reset();
    pulse_ina = 1'b1;
    repeat (20) tick();
    pulse_ina = 1'b0;
    chk("ovf_pend_sat", 32'(pend_a), 15);
    chk("ovf_set",      32'(ovf_a),  1);
    chk("ovf_req",      32'(req_a),  1);
`ifdef PULSE_TX_TIMEOUT_EN
    chk("ovf_to_err",   32'(to_err_a), 1);
`else
    chk("ovf_to_err",   32'(to_err_a), 0);
`endif
    clr_ina = 1'b1;
    tick();
    chk("ovf_clr",      32'(ovf_a),    0);
    chk("ovf_clr_to",   32'(to_err_a), 0);
    pulse_ina = 1'b1;
    tick();
    pulse_ina = 1'b0;
    chk("ovf_set_wins", 32'(ovf_a),  1);
    chk("ovf_pend_hold", 32'(pend_a), 15);
    clr_ina = 1'b0;
    tick();
    chk("ovf_sticky",   32'(ovf_a),  1);
    clr_ina = 1'b1;
    tick();
    clr_ina = 1'b0;
    chk("ovf_clr2",     32'(ovf_a),  0);

    // Pulse on the launch cycle
    do_reset();
    pulse_ina = 1'b1;
    tick();
    chk("sim_pend_a",   32'(pend_a), 1);
    chk("sim_req_a",    32'(req_a),  0);
    tick();
    pulse_ina = 1'b0;
    chk("sim_pend_b",   32'(pend_a), 1);
    chk("sim_req_b",    32'(req_a),  1);
    tick();
    chk("sim_pend_c",   32'(pend_a), 1);

    // Reset during REQ with three queued
    do_reset();
    pulse_ina = 1'b1;
    repeat (4) tick();
    pulse_ina = 1'b0;
    chk("mid_pend3",    32'(pend_a), 3);
    chk("mid_req1",     32'(req_a),  1);
    rst_n = 1'b0;
    tick();
    chk("mid_req0",     32'(req_a),  0);
    chk("mid_pend0",    32'(pend_a), 0);
    chk("mid_busy0",    32'(busy_a), 0);
    chk("mid_done0",    32'(done_a), 0);
    rst_n = 1'b1;
    dones = 0;
    repeat (6) begin
      tick();
      if (done_a) dones++;
    end
    chk("mid_no_done",  32'(dones), 0);
    chk("mid_stay_idle", 32'(req_a), 0);

    // Acknowledge never returns
    do_reset();
    pulse_ina = 1'b1;
    tick();
    tick();
    pulse_ina = 1'b0;
    chk("to_launch",    32'(req_a),  1);
    chk("to_pend1",     32'(pend_a), 1);
    dones = 0;
    repeat (15) begin
      tick();
      if (done_a) dones++;
    end
    chk("to_req_15",    32'(req_a),  1);
    tick();
    if (done_a) dones++;
`ifdef PULSE_TX_TIMEOUT_EN
    chk("to_req_drop",  32'(req_a),    0);
    chk("to_err_set",   32'(to_err_a), 1);
    chk("to_idle",      32'(busy_a),   0);
    tick();
    if (done_a) dones++;
    chk("to_relaunch",  32'(req_a),    1);
    chk("to_pend0",     32'(pend_a),   0);
`else
    chk("to_req_hold",  32'(req_a),    1);
    chk("to_err_zero",  32'(to_err_a), 0);
    repeat (40) begin
      tick();
      if (done_a) dones++;
    end
    chk("to_req_long",  32'(req_a),    1);
    chk("to_pend_keep", 32'(pend_a),   1);
`endif
    chk("to_no_done",   32'(dones), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
